// File: rtl/iso7816_3_t0_tpdu_monitor.sv
// iso7816_3_t0_tpdu_monitor
// Passive T=0 TPDU tracker: follows header, procedure bytes, data and status
// word on the received byte stream, predicts the next transmitter, captures
// header/status word, counts TPDUs, enforces an inter-byte timeout and flags
// protocol violations.
// Optional build macro: T0_MONITOR_STRICT_SW_EN restricts SW1 to 0x61-0x6F and
// 0x90-0x9F, and rejects SW1=0x6C with SW2=0x00.
//
// state    | meaning
// IDLE     | monitor disabled (ATR not done or T=0 not selected)
// HEADER   | collecting CLA INS P1 P2 P3 from the terminal
// PROC     | waiting for a procedure byte from the card
// DATA_ALL | transferring all remaining data bytes
// DATA_ONE | transferring a single data byte
// SW2      | SW1 seen, waiting for SW2
// ERROR    | protocol violation, bytes ignored until resync or timeout
module iso7816_3_t0_tpdu_monitor #(
   parameter int DATA_CNT_WIDTH = 9,
   parameter int WAIT_CNT_WIDTH = 24,
   parameter int TPDU_CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [7:0]                rxByte,
   input  logic                      rxByteValid,
   input  logic                      insIsWrite,
   input  logic [WAIT_CNT_WIDTH-1:0] waitTimeCycles,
   input  logic                      resync,
   output logic [2:0]                state,
   output logic                      waitCardTx,
   output logic                      waitTermTx,
   output logic [39:0]               tpduHeader,
   output logic [15:0]               statusWord,
   output logic [DATA_CNT_WIDTH-1:0] dataRemaining,
   output logic                      tpduDone,
   output logic [TPDU_CNT_WIDTH-1:0] tpduCnt,
   output logic                      protocolError,
   output logic                      timeoutError
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_HEADER   = 3'd1,
      S_PROC     = 3'd2,
      S_DATA_ALL = 3'd3,
      S_DATA_ONE = 3'd4,
      S_SW2      = 3'd5,
      S_ERROR    = 3'd6
   } state_t;

   state_t                    state_q, state_d;
   logic [39:0]               hdr_q, hdr_d;
   logic [2:0]                idx_q, idx_d;
   logic                      write_q, write_d;
   logic [7:0]                sw1_q, sw1_d;
   logic [15:0]               sw_q, sw_d;
   logic [DATA_CNT_WIDTH-1:0] rem_q, rem_d;
   logic                      done_q, done_d;
   logic [TPDU_CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                      perr_q, perr_d;
   logic                      tout_q, tout_d;
   logic [WAIT_CNT_WIDTH-1:0] tmr_q, tmr_d;

   logic [7:0] ins;
   logic       sw1_cand;
   logic       tmr_run;
   logic       tmo;

   assign ins = hdr_q[31:24];

`ifdef T0_MONITOR_STRICT_SW_EN
   assign sw1_cand = ((rxByte[7:4] == 4'h6) && (rxByte[3:0] != 4'h0)) ||
                     (rxByte[7:4] == 4'h9);
`else
   assign sw1_cand = 1'b1;
`endif

   // The header phase only times out once the terminal has started a header.
   assign tmr_run = (state_q == S_PROC) || (state_q == S_DATA_ALL) ||
                    (state_q == S_DATA_ONE) || (state_q == S_SW2) ||
                    (state_q == S_ERROR) ||
                    ((state_q == S_HEADER) && (idx_q != 3'd0));
   assign tmo = tmr_run && (waitTimeCycles != '0) && (tmr_q == waitTimeCycles);

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         hdr_q   <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         sw1_q   <= '0;
         sw_q    <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         perr_q  <= 1'b0;
         tout_q  <= 1'b0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         hdr_q   <= hdr_d;
         idx_q   <= idx_d;
         write_q <= write_d;
         sw1_q   <= sw1_d;
         sw_q    <= sw_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         perr_q  <= perr_d;
         tout_q  <= tout_d;
         tmr_q   <= tmr_d;
      end
   end

   // Next state and datapath; priority enable, resync, strobe, timeout.
   always_comb begin
      state_d = state_q;
      hdr_d   = hdr_q;
      idx_d   = idx_q;
      write_d = write_q;
      sw1_d   = sw1_q;
      sw_d    = sw_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      perr_d  = perr_q;
      tout_d  = 1'b0;
      if (!enable) begin
         state_d = S_IDLE;
         idx_d   = '0;
         rem_d   = '0;
      end else if (state_q == S_IDLE) begin
         state_d = S_HEADER;
      end else if (resync) begin
         state_d = S_HEADER;
         idx_d   = '0;
         rem_d   = '0;
         perr_d  = 1'b0;
      end else if (rxByteValid) begin
         case (state_q)
            S_HEADER: begin
               hdr_d = {hdr_q[31:0], rxByte};
               if (idx_q == 3'd1) write_d = insIsWrite;
               if (idx_q == 3'd4) begin
                  // P3=0 means 256 bytes for outgoing data, none for incoming.
                  if (rxByte == 8'h00)
                     rem_d = write_q ? '0 : DATA_CNT_WIDTH'(256);
                  else
                     rem_d = DATA_CNT_WIDTH'(rxByte);
                  idx_d   = '0;
                  state_d = S_PROC;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
            S_PROC: begin
               if (rxByte == 8'h60) begin
                  state_d = S_PROC;
               end else if (rxByte == ins) begin
                  state_d = (rem_q != '0) ? S_DATA_ALL : S_ERROR;
               end else if (rxByte == ~ins) begin
                  state_d = (rem_q != '0) ? S_DATA_ONE : S_ERROR;
               end else if (sw1_cand) begin
                  sw1_d   = rxByte;
                  state_d = S_SW2;
               end else begin
                  state_d = S_ERROR;
               end
               if (state_d == S_ERROR) perr_d = 1'b1;
            end
            S_DATA_ALL: begin
               rem_d = rem_q - DATA_CNT_WIDTH'(1);
               if (rem_q == DATA_CNT_WIDTH'(1)) state_d = S_PROC;
            end
            S_DATA_ONE: begin
               rem_d   = rem_q - DATA_CNT_WIDTH'(1);
               state_d = S_PROC;
            end
            S_SW2: begin
`ifdef T0_MONITOR_STRICT_SW_EN
               if ((sw1_q == 8'h6C) && (rxByte == 8'h00)) begin
                  state_d = S_ERROR;
                  perr_d  = 1'b1;
               end else
`endif
               begin
                  sw_d    = {sw1_q, rxByte};
                  done_d  = 1'b1;
                  cnt_d   = cnt_q + TPDU_CNT_WIDTH'(1);
                  state_d = S_HEADER;
               end
            end
            default: ;
         endcase
      end else if (tmo) begin
         tout_d  = 1'b1;
         state_d = S_HEADER;
         idx_d   = '0;
      end
   end

   // Inter-byte timer: restarts on any byte, state change or expiry.
   always_comb begin
      tmr_d = '0;
      if (enable && !resync && !rxByteValid && !tmo &&
          (state_d == state_q) && tmr_run)
         tmr_d = tmr_q + WAIT_CNT_WIDTH'(1);
   end

   // Outputs: expected transmitter decoded from the current state.
   always_comb begin
      waitCardTx = 1'b0;
      waitTermTx = 1'b0;
      case (state_q)
         S_HEADER:               waitTermTx = 1'b1;
         S_PROC, S_SW2:          waitCardTx = 1'b1;
         S_DATA_ALL, S_DATA_ONE: begin
            waitTermTx = write_q;
            waitCardTx = !write_q;
         end
         default: ;
      endcase
   end

   assign state         = state_q;
   assign tpduHeader    = hdr_q;
   assign statusWord    = sw_q;
   assign dataRemaining = rem_q;
   assign tpduDone      = done_q;
   assign tpduCnt       = cnt_q;
   assign protocolError = perr_q;
   assign timeoutError  = tout_q;

endmodule

// File: tb/tb_iso7816_3_t0_tpdu_monitor.sv
// Testbench for iso7816_3_t0_tpdu_monitor: directed TPDU sequences with a
// scoreboard for completed TPDUs and timeout pulses.
module tb_iso7816_3_t0_tpdu_monitor;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [7:0]  rxByte = 8'h00;
   logic        rxByteValid = 1'b0;
   logic        insIsWrite = 1'b0;
   logic [23:0] waitTimeCycles = 24'd0;
   logic        resync = 1'b0;
   logic [2:0]  state;
   logic        waitCardTx, waitTermTx;
   logic [39:0] tpduHeader;
   logic [15:0] statusWord;
   logic [8:0]  dataRemaining;
   logic        tpduDone;
   logic [15:0] tpduCnt;
   logic        protocolError;
   logic        timeoutError;

   iso7816_3_t0_tpdu_monitor dut (
      .clk(clk), .reset(reset), .enable(enable), .rxByte(rxByte),
      .rxByteValid(rxByteValid), .insIsWrite(insIsWrite),
      .waitTimeCycles(waitTimeCycles), .resync(resync), .state(state),
      .waitCardTx(waitCardTx), .waitTermTx(waitTermTx),
      .tpduHeader(tpduHeader), .statusWord(statusWord),
      .dataRemaining(dataRemaining), .tpduDone(tpduDone), .tpduCnt(tpduCnt),
      .protocolError(protocolError), .timeoutError(timeoutError)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] sw;
      logic [15:0] cnt;
   } done_exp_t;

   done_exp_t exp_done_q[$];
   int        exp_tmo_q[$];
   int        n_cmp = 0;
   int        n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at posedge+1; the strobe is sampled at the next edge.
   task automatic send(input logic [7:0] b, input logic w);
      rxByte      = b;
      insIsWrite  = w;
      rxByteValid = 1'b1;
      @(posedge clk);
      #1;
      rxByteValid = 1'b0;
      insIsWrite  = 1'b0;
   endtask

   task automatic send_hdr(input logic [39:0] h, input logic w);
      logic [39:0] hv;
      hv = h;
      for (int i = 0; i < 5; i++) send(hv[39-8*i -: 8], (i == 1) ? w : 1'b0);
   endtask

   task automatic do_resync();
      resync = 1'b1;
      @(posedge clk);
      #1;
      resync = 1'b0;
   endtask

   task automatic push_done(input logic [15:0] sw, input logic [15:0] cnt);
      done_exp_t e;
      e.sw  = sw;
      e.cnt = cnt;
      exp_done_q.push_back(e);
   endtask

   // Monitor: every output pulse must match a queued expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (tpduDone) begin
            if (exp_done_q.size() == 0) begin
               chk("unexpected_tpduDone", 64'(tpduDone), 64'd0);
            end else begin
               done_exp_t e;
               e = exp_done_q.pop_front();
               chk("statusWord", 64'(statusWord), 64'(e.sw));
               chk("tpduCnt", 64'(tpduCnt), 64'(e.cnt));
            end
         end
         if (timeoutError) begin
            if (exp_tmo_q.size() == 0) begin
               chk("unexpected_timeout", 64'(timeoutError), 64'd0);
            end else begin
               void'(exp_tmo_q.pop_front());
               chk("timeout_state", 64'(state), 64'd1);
            end
         end
      end
   end

   initial begin
      // Reset state
      #2;
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_outputs", 64'({waitCardTx, waitTermTx, tpduDone, protocolError, timeoutError}), 64'd0);
      chk("rst_hdr_sw_cnt", 64'({tpduHeader, statusWord, tpduCnt} != 0), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_disabled", 64'(state), 64'd0);
      enable = 1'b1;
      @(posedge clk); #1;
      chk("enter_header", 64'(state), 64'd1);
      chk("header_waitTerm", 64'({waitCardTx, waitTermTx}), 64'b01);

      // Write TPDU, ACK with INS
      send_hdr(40'h00D6000002, 1'b1);
      chk("A_hdr", 64'(tpduHeader), 64'h00D6000002);
      chk("A_proc", 64'(state), 64'd2);
      chk("A_rem", 64'(dataRemaining), 64'd2);
      chk("A_proc_waitCard", 64'({waitCardTx, waitTermTx}), 64'b10);
      send(8'hD6, 1'b0);
      chk("A_data_all", 64'(state), 64'd3);
      chk("A_write_dir", 64'({waitCardTx, waitTermTx}), 64'b01);
      send(8'hAA, 1'b0);
      chk("A_rem1", 64'(dataRemaining), 64'd1);
      send(8'hBB, 1'b0);
      chk("A_rem0", 64'(dataRemaining), 64'd0);
      chk("A_back_proc", 64'(state), 64'd2);
      push_done(16'h9000, 16'd1);
      send(8'h90, 1'b0);
      chk("A_sw2", 64'(state), 64'd5);
      send(8'h00, 1'b0);
      chk("A_done_header", 64'(state), 64'd1);

      // Read TPDU with P3=0 -> 256 bytes
      send_hdr(40'h00B0000000, 1'b0);
      chk("B_rem256", 64'(dataRemaining), 64'd256);
      send(8'hB0, 1'b0);
      chk("B_read_dir", 64'({waitCardTx, waitTermTx}), 64'b10);
      for (int i = 0; i < 255; i++) send(8'(i), 1'b0);
      chk("B_rem1", 64'(dataRemaining), 64'd1);
      chk("B_still_data", 64'(state), 64'd3);
      send(8'hFF, 1'b0);
      chk("B_rem0", 64'(dataRemaining), 64'd0);
      chk("B_proc", 64'(state), 64'd2);
      push_done(16'h9000, 16'd2);
      send(8'h90, 1'b0);
      send(8'h00, 1'b0);

      // Byte-by-byte with NULL
      send_hdr(40'h00D6000002, 1'b1);
      send(8'h60, 1'b0);
      chk("C_null_proc", 64'(state), 64'd2);
      send(8'h29, 1'b0);
      chk("C_data_one_a", 64'(state), 64'd4);
      chk("C_one_dir", 64'({waitCardTx, waitTermTx}), 64'b01);
      send(8'hAA, 1'b0);
      chk("C_proc_a", 64'({state, dataRemaining}), 64'({3'd2, 9'd1}));
      send(8'h29, 1'b0);
      chk("C_data_one_b", 64'(state), 64'd4);
      send(8'hBB, 1'b0);
      chk("C_proc_b", 64'({state, dataRemaining}), 64'({3'd2, 9'd0}));
      push_done(16'h9000, 16'd3);
      send(8'h90, 1'b0);
      send(8'h00, 1'b0);

      // Timeout after three header bytes
      waitTimeCycles = 24'd100;
      send(8'h00, 1'b0); send(8'hA4, 1'b0); send(8'h00, 1'b0);
      exp_tmo_q.push_back(1);
      repeat (100) @(posedge clk);
      #1;
      chk("D_no_early_tmo", 64'(timeoutError), 64'd0);
      @(posedge clk); #1;
      chk("D_tmo_pulse", 64'(timeoutError), 64'd1);
      chk("D_tmo_header", 64'(state), 64'd1);
      @(posedge clk); #1;
      chk("D_tmo_one_cycle", 64'(timeoutError), 64'd0);
      // Strobe coincident with the timeout is consumed instead
      send(8'h00, 1'b0); send(8'hA4, 1'b0); send(8'h00, 1'b0);
      repeat (100) @(posedge clk);
      #1;
      send(8'h04, 1'b0);
      send(8'h02, 1'b0);
      chk("D_strobe_wins", 64'({state, tpduHeader}), 64'({3'd2, 40'h00A4000402}));
      do_resync();
      chk("D_resync", 64'({state, dataRemaining}), 64'({3'd1, 9'd0}));
      waitTimeCycles = 24'd0;

      // Non-standard procedure byte 0x42
      for (int i = 0; i < 4; i++) send(8'(8'hC0 & {8{i == 1}}), 1'b0);
      chk("E_idx_restart", 64'(state), 64'd1);
      send(8'h02, 1'b0);
      chk("E_proc", 64'(state), 64'd2);
      send(8'h42, 1'b0);
`ifdef T0_MONITOR_STRICT_SW_EN
      chk("E_strict_error", 64'({state, protocolError}), 64'({3'd6, 1'b1}));
      do_resync();
      chk("E_strict_resync", 64'({state, protocolError}), 64'({3'd1, 1'b0}));
`else
      chk("E_sw1_latched", 64'(state), 64'd5);
      push_done(16'h4217, 16'd4);
      send(8'h17, 1'b0);
      chk("E_done_header", 64'(state), 64'd1);
`endif

      // ACK with nothing to transfer -> ERROR, bytes ignored, resync clears
      send_hdr(40'h00D6000000, 1'b1);
      chk("F_rem0", 64'(dataRemaining), 64'd0);
      send(8'hD6, 1'b0);
      chk("F_error", 64'({state, protocolError}), 64'({3'd6, 1'b1}));
      chk("F_no_wait", 64'({waitCardTx, waitTermTx}), 64'b00);
      send(8'h90, 1'b0);
      send(8'h00, 1'b0);
      chk("F_ignored", 64'(state), 64'd6);
      do_resync();
      chk("F_resync", 64'({state, protocolError}), 64'({3'd1, 1'b0}));

      // enable drop in DATA_ALL
      send_hdr(40'h00B0000004, 1'b0);
      send(8'hB0, 1'b0);
      send(8'h11, 1'b0);
      chk("G_data", 64'({state, dataRemaining}), 64'({3'd3, 9'd3}));
      enable = 1'b0;
      @(posedge clk); #1;
      chk("G_idle", 64'({state, protocolError, waitCardTx, waitTermTx}), 64'({3'd0, 3'b000}));
      enable = 1'b1;
      @(posedge clk); #1;
      chk("G_reenable", 64'(state), 64'd1);

      // Asynchronous reset mid-TPDU
      send_hdr(40'h00D6000002, 1'b1);
      send(8'hD6, 1'b0);
      send(8'hAA, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("H_async_state", 64'({state, dataRemaining}), 64'd0);
      chk("H_async_regs", 64'({tpduHeader, statusWord, tpduCnt} != 0), 64'd0);
      chk("H_async_flags", 64'({waitCardTx, waitTermTx, protocolError}), 64'd0);
      @(posedge clk); #1;

      chk("pending_done", 64'(exp_done_q.size()), 64'd0);
      chk("pending_timeout", 64'(exp_tmo_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/iso7816_3_t0_tpdu_monitor.md
# iso7816_3_t0_tpdu_monitor

Passive T=0 TPDU tracker fed by the receive byte stream of the ISO7816-3 analyzer once the ATR is complete. It follows the T=0 command/response sequence (header, procedure bytes, data, SW1/SW2), drives the expected-transmitter flags (waitCardTx/waitTermTx), and captures header, status word and counts. It enforces a parametrised inter-byte timeout and flags protocol violations.

## Interface
- DATA_CNT_WIDTH, 9: data byte counter width; must be ≥9 so that P3=0 maps to 256.
- WAIT_CNT_WIDTH, 24: width of the inter-byte timeout counter and waitTimeCycles.
- TPDU_CNT_WIDTH, 16: width of the completed-TPDU counter.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  high when the ATR is completed and T=0 is selected; low forces IDLE.
- rxByte  in  8  decoded byte, already convention-corrected.
- rxByteValid  in  1  one-cycle strobe; rxByte is valid in that cycle.
- insIsWrite  in  1  external INS decode, sampled with the INS byte; 1 = data flows terminal→card.
- waitTimeCycles  in  WAIT_CNT_WIDTH  inter-byte timeout in clk cycles; 0 disables the timeout.
- resync  in  1  one-cycle pulse: abandon the current TPDU and go to HEADER.
- state  out  3  IDLE=0, HEADER=1, PROC=2, DATA_ALL=3, DATA_ONE=4, SW2=5, ERROR=6.
- waitCardTx, waitTermTx  out  1 each  expected next transmitter.
- tpduHeader  out  40  {CLA,INS,P1,P2,P3}.
- statusWord  out  16  {SW1,SW2} of the last completed TPDU.
- dataRemaining  out  DATA_CNT_WIDTH  data bytes still expected.
- tpduDone  out  1  one-cycle pulse when SW2 is captured.
- tpduCnt  out  TPDU_CNT_WIDTH  count of completed TPDUs; wraps.
- protocolError  out  1  sticky; cleared by resync or reset.
- timeoutError  out  1  one-cycle pulse on timeout.

## Operation
- Reset: state=IDLE. All outputs are 0, the header byte index is 0, and the timeout counter is 0.
- IDLE: waitCardTx=waitTermTx=0. When enable=1, go to HEADER.
- HEADER: waitTermTx=1. Each strobe shifts rxByte into tpduHeader (MSB first) and increments the index.
  - At the INS byte, latch insIsWrite.
  - At the fifth byte (P3), dataRemaining = (P3==0) ? (write ? 0 : 256) : P3. Then go to PROC with the index cleared.
- PROC: waitCardTx=1. The procedure byte b is handled as follows:
  - b==0x60 (NULL): stay in PROC.
  - b==INS: go to DATA_ALL if dataRemaining≠0; otherwise go to ERROR.
  - b==INS^0xFF: go to DATA_ONE if dataRemaining≠0; otherwise go to ERROR.
  - b is an SW1 candidate: latch SW1 and go to SW2.
  - Any other value: go to ERROR.
- DATA_ALL: direction is set by the latched write flag (write → waitTermTx, else waitCardTx). Each strobe decrements dataRemaining. When it reaches 0, go to PROC.
- DATA_ONE: same direction rule. One strobe decrements dataRemaining and returns to PROC.
- SW2: waitCardTx=1. The strobe latches statusWord={SW1,rxByte}, pulses tpduDone, increments tpduCnt, and goes to HEADER.
- ERROR: protocolError=1 and both wait flags are 0. Bytes are ignored. Exit to HEADER only on resync or timeout.
- Timeout counter:
  - Cleared on every strobe and on every state change.
  - Counts in PROC, DATA_ALL, DATA_ONE, SW2, ERROR, and in HEADER when index≠0. It is idle in HEADER at index 0 and in IDLE.
  - When counter==waitTimeCycles and waitTimeCycles≠0: pulse timeoutError, go to HEADER with index 0, and leave protocolError unchanged.
- Priority, highest first: enable=0, resync, rxByteValid, timeout.
  - A strobe coincident with timeout is consumed and no timeout fires.
  - A strobe coincident with resync is dropped.
- resync clears protocolError, the header index and dataRemaining. It leaves tpduHeader, statusWord and tpduCnt unchanged.
- enable falling mid-TPDU: go to IDLE next cycle, discard partial state and raise no error.

## Timing
- Every output is registered and reflects a strobe on the following rising edge, i.e. 1-cycle latency.
- tpduDone and timeoutError are high for exactly one clk cycle.
- The timeout fires waitTimeCycles cycles after the last clear.
- Back-to-back strobes on consecutive cycles are accepted.
- An asynchronous reset mid-TPDU returns every output to its reset value immediately.

## Configuration
- T0_MONITOR_STRICT_SW_EN defined:
  - SW1 candidates are only 0x61–0x6F and 0x90–0x9F.
  - Any other non-NULL, non-ACK procedure byte goes to ERROR.
  - In SW2, SW1=0x6C with SW2=0x00 also goes to ERROR.
- Undefined:
  - Any byte that is not 0x60, INS or INS^0xFF is treated as SW1.
  - SW2 is never checked.

## Test plan
- Write TPDU: header 00 D6 00 00 02 (insIsWrite=1), then B0? no: proc D6, data AA BB, then 90 00 → DATA_ALL with waitTermTx=1, dataRemaining 2→0, statusWord=0x9000, tpduDone once, tpduCnt=1.
- Read TPDU with P3=00 (insIsWrite=0): header 00 B0 00 00 00, proc B0, 256 data bytes, then 90 00 → dataRemaining starts at 256 and ends at 0, then PROC then SW2.
- Byte-by-byte: header 00 D6 00 00 02, then 60, 29, AA, 29, BB, 90 00 → NULL keeps PROC; DATA_ONE entered twice; completes with tpduCnt incremented.
- Timeout: waitTimeCycles=100, send three header bytes, then idle → timeoutError pulses at cycle 100 after the third byte; state=HEADER with index 0; a strobe at cycle 100 instead consumes the byte and no pulse fires.
- Illegal procedure byte 0x42 → state ERROR and protocolError=1. Bytes are ignored; resync → HEADER with protocolError=0. With T0_MONITOR_STRICT_SW_EN undefined, 0x42 is latched as SW1.
- enable drops while in DATA_ALL → IDLE next cycle with no error; assert reset mid-TPDU → all outputs 0 asynchronously.
